// File: rtl/timer_regs_param.sv
// timer_regs_param: byte-bus register file for the timer core.
// Ports: host byte bus (module_en/wr/addr/wdata/rdata), core status inputs
// (count_in/overflow/match), control/limit/match outputs, status and irq.
// Build macro TIMER_REGS_ATOMIC_EN enables staged wide writes and COUNT snapshot.
module timer_regs_param #(
  parameter int CNT_W   = 16,
  parameter int N_MATCH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     module_en,
  input  logic                     wr,
  input  logic [5:0]               addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  input  logic [CNT_W-1:0]         count_in,
  input  logic                     overflow,
  input  logic [N_MATCH-1:0]       match,
  output logic                     start,
  output logic                     count_mode,
  output logic                     clock_select,
  output logic                     force_free,
  output logic                     edge_mode,
  output logic [2:0]               prescaler,
  output logic                     pwm_mode,
  output logic                     inv,
  output logic                     ovf_int_en,
  output logic [N_MATCH-1:0]       match_int_en,
  output logic                     ovf_trg_en,
  output logic [N_MATCH-1:0]       match_trg_en,
  output logic [CNT_W-1:0]         count_init,
  output logic [CNT_W-1:0]         count_min,
  output logic [CNT_W-1:0]         count_max,
  output logic [N_MATCH*CNT_W-1:0] match_value,
  output logic                     cnt_init_wr,
  output logic                     cnt_load,
  output logic [CNT_W-1:0]         cnt_load_val,
  output logic [N_MATCH:0]         status,
  output logic                     irq
);

  localparam int NB = CNT_W / 8;
  localparam int NS = N_MATCH + 1;

  logic          wr_en;
  logic          rd_en;
  logic [3:0]    slot;
  logic [1:0]    bsel;
  logic          byte_ok;
  logic          is_msb;
  logic          is_match;
  logic          wide_ok;
  logic          wide_wr;
  logic          commit;
  logic [7:0]    ctrl;
  logic [7:0]    ctrl_in;
  logic [7:0]    ctrl_out;
  logic [NS-1:0] int_en;
  logic [NS-1:0] trg_en;
  logic [NS-1:0] st_set;
  logic [NS-1:0] st_clr;
  logic [CNT_W-1:0] stage;
  logic [CNT_W-1:0] snap;
  logic [CNT_W-1:0] rword;
  logic [7:0]    rbyte;
  logic [7:0]    rmux;

  assign wr_en    = module_en & wr;
  assign rd_en    = module_en & ~wr;
  assign slot     = addr[5:2];
  assign bsel     = addr[1:0];
  assign byte_ok  = int'(bsel) < NB;
  assign is_msb   = int'(bsel) == NB - 1;
  assign is_match = slot >= 4'd6 && int'(slot) - 6 < N_MATCH;
  assign wide_ok  = (slot >= 4'd2 && slot <= 4'd5) || is_match;
  assign wide_wr  = wr_en & wide_ok & byte_ok;

`ifdef TIMER_REGS_ATOMIC_EN
  localparam bit ATOMIC = 1'b1;

  // Lower bytes park in a stage shared by all slots; the
  // MSB write commits. Byte 0 of COUNT freezes the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
      snap  <= '0;
    end else begin
      if (wide_wr && !is_msb)
        stage <= put_byte(stage, bsel, wdata);
      if (rd_en && addr == 6'h14)
        snap <= count_in;
    end
  end
`else
  localparam bit ATOMIC = 1'b0;
  assign stage = '0;
  assign snap  = '0;
`endif

  assign commit = wide_wr & (is_msb | ~ATOMIC);

  function automatic logic [CNT_W-1:0] put_byte(
    input logic [CNT_W-1:0] v,
    input logic [1:0]       b,
    input logic [7:0]       d
  );
    logic [CNT_W-1:0] r;
    r = v;
    for (int k = 0; k < NB; k++)
      if (int'(b) == k) r[k*8 +: 8] = d;
    return r;
  endfunction

  // On an atomic commit bsel is the MSB, so the stage
  // supplies the low bytes; otherwise patch one byte.
  function automatic logic [CNT_W-1:0] upd(
    input logic [CNT_W-1:0] old
  );
    return put_byte(ATOMIC ? stage : old, bsel, wdata);
  endfunction

  assign st_set = {match & {N_MATCH{start}}, overflow};
  assign st_clr = (wr_en && addr == 6'h04) ?
                  wdata[NS-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl         <= '0;
      ctrl_in      <= '0;
      ctrl_out     <= '0;
      int_en       <= '0;
      trg_en       <= '0;
      status       <= '0;
      irq          <= 1'b0;
      count_init   <= '0;
      count_min    <= '0;
      count_max    <= '1;
      match_value  <= '0;
      cnt_init_wr  <= 1'b0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
    end else begin
      irq         <= |(status & int_en);
      status      <= (status & ~st_clr) | st_set;
      cnt_init_wr <= commit && slot == 4'd2;
      cnt_load    <= commit && slot == 4'd5;
      if (wr_en) begin
        unique case (1'b1)
          addr == 6'h00: ctrl     <= wdata & 8'h8B;
          addr == 6'h01: ctrl_in  <= wdata & 8'h71;
          addr == 6'h02: ctrl_out <= wdata & 8'h03;
          addr == 6'h03: int_en   <= wdata[NS-1:0];
          addr == 6'h05: trg_en   <= wdata[NS-1:0];
          default: ;
        endcase
      end
      if (commit) begin
        unique case (1'b1)
          slot == 4'd2: count_init   <= upd(count_init);
          slot == 4'd3: count_min    <= upd(count_min);
          slot == 4'd4: count_max    <= upd(count_max);
          slot == 4'd5: cnt_load_val <= upd(cnt_load_val);
          default: ;
        endcase
        for (int i = 0; i < N_MATCH; i++)
          if (int'(slot) == 6 + i)
            match_value[i*CNT_W +: CNT_W] <=
              upd(match_value[i*CNT_W +: CNT_W]);
      end
    end
  end

  assign start        = ctrl[0];
  assign count_mode   = ctrl[1];
  assign clock_select = ctrl[3];
  assign force_free   = ctrl[7];
  assign edge_mode    = ctrl_in[0];
  assign prescaler    = ctrl_in[6:4];
  assign pwm_mode     = ctrl_out[0];
  assign inv          = ctrl_out[1];
  assign ovf_int_en   = int_en[0];
  assign match_int_en = int_en[NS-1:1];
  assign ovf_trg_en   = trg_en[0];
  assign match_trg_en = trg_en[NS-1:1];

  always_comb begin
    rword = '0;
    unique case (1'b1)
      slot == 4'd2: rword = count_init;
      slot == 4'd3: rword = count_min;
      slot == 4'd4: rword = count_max;
      slot == 4'd5: rword = (ATOMIC && bsel != 2'd0) ?
                            snap : count_in;
      default: ;
    endcase
    for (int i = 0; i < N_MATCH; i++)
      if (int'(slot) == 6 + i)
        rword = match_value[i*CNT_W +: CNT_W];
    rbyte = '0;
    for (int k = 0; k < NB; k++)
      if (int'(bsel) == k) rbyte = rword[k*8 +: 8];
    rmux = '0;
    unique case (1'b1)
      addr == 6'h00: rmux = ctrl;
      addr == 6'h01: rmux = ctrl_in;
      addr == 6'h02: rmux = ctrl_out;
      addr == 6'h03: rmux = 8'(int_en);
      addr == 6'h04: rmux = 8'(status);
      addr == 6'h05: rmux = 8'(trg_en);
      addr == 6'h06: rmux = 8'(status & int_en);
      wide_ok:       rmux = rbyte;
      default: ;
    endcase
    rdata = rd_en ? rmux : 8'h00;
  end

endmodule

// File: tb/tb_timer_regs_param.sv
// tb_timer_regs_param: directed and randomized checks of
// timer_regs_param against a byte-level register model.
module tb_timer_regs_param;

  localparam int CNT_W   = 16;
  localparam int N_MATCH = 2;
  localparam int NB      = CNT_W / 8;
  localparam int NS      = N_MATCH + 1;
`ifdef TIMER_REGS_ATOMIC_EN
  localparam bit ATOM = 1'b1;
`else
  localparam bit ATOM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic module_en = 1'b0;
  logic wr = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic [CNT_W-1:0] count_in = '0;
  logic overflow = 1'b0;
  logic [N_MATCH-1:0] match = '0;
  logic start, count_mode, clock_select, force_free;
  logic edge_mode, pwm_mode, inv, ovf_int_en, ovf_trg_en;
  logic [2:0] prescaler;
  logic [N_MATCH-1:0] match_int_en, match_trg_en;
  logic [CNT_W-1:0] count_init, count_min, count_max;
  logic [N_MATCH*CNT_W-1:0] match_value;
  logic cnt_init_wr, cnt_load, irq;
  logic [CNT_W-1:0] cnt_load_val;
  logic [N_MATCH:0] status;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer_regs_param #(.CNT_W(CNT_W), .N_MATCH(N_MATCH)) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .count_in(count_in), .overflow(overflow), .match(match),
    .start(start), .count_mode(count_mode),
    .clock_select(clock_select), .force_free(force_free),
    .edge_mode(edge_mode), .prescaler(prescaler),
    .pwm_mode(pwm_mode), .inv(inv),
    .ovf_int_en(ovf_int_en), .match_int_en(match_int_en),
    .ovf_trg_en(ovf_trg_en), .match_trg_en(match_trg_en),
    .count_init(count_init), .count_min(count_min),
    .count_max(count_max), .match_value(match_value),
    .cnt_init_wr(cnt_init_wr), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .status(status), .irq(irq)
  );

  logic [511:0] act;
  assign act = 512'({start, count_mode, clock_select,
    force_free, edge_mode, prescaler, pwm_mode, inv,
    ovf_int_en, match_int_en, ovf_trg_en, match_trg_en,
    count_init, count_min, count_max, match_value,
    cnt_init_wr, cnt_load, cnt_load_val, status, irq});

  // Register model: one byte/word per architectural register
  logic [7:0]       m_ctrl, m_cin, m_cout;
  logic [NS-1:0]    m_ie, m_te, m_st;
  logic             m_irq, m_init_p, m_load_p;
  logic [CNT_W-1:0] m_wide [16];
  logic [7:0]       m_stage [4];
  logic [CNT_W-1:0] m_snap;

  task automatic m_reset();
    m_ctrl = 0; m_cin = 0; m_cout = 0;
    m_ie = 0; m_te = 0; m_st = 0;
    m_irq = 0; m_init_p = 0; m_load_p = 0;
    for (int i = 0; i < 16; i++) m_wide[i] = '0;
    m_wide[4] = '1;
    for (int i = 0; i < 4; i++) m_stage[i] = 8'h00;
    m_snap = '0;
  endtask

  function automatic bit m_mapped(input int s);
    return (s >= 2 && s <= 5) || (s >= 6 && s - 6 < N_MATCH);
  endfunction

  function automatic logic [7:0] m_read(
    input int a, input logic [CNT_W-1:0] cin);
    int s, b;
    logic [CNT_W-1:0] v;
    s = a / 4; b = a % 4;
    case (a)
      0: return m_ctrl;
      1: return m_cin;
      2: return m_cout;
      3: return 8'(m_ie);
      4: return 8'(m_st);
      5: return 8'(m_te);
      6: return 8'(m_st & m_ie);
      default: ;
    endcase
    if (a < 8 || b >= NB || !m_mapped(s)) return 8'h00;
    if (s == 5) v = (ATOM && b != 0) ? m_snap : cin;
    else v = m_wide[s];
    return 8'(v >> (8 * b));
  endfunction

  task automatic m_edge(input logic en, input logic w,
    input int a, input logic [7:0] d,
    input logic [CNT_W-1:0] cin, input logic ovf,
    input logic [N_MATCH-1:0] m);
    logic [NS-1:0] set, clr;
    logic [CNT_W-1:0] nv;
    int s, b;
    s = a / 4; b = a % 4;
    set = {m & {N_MATCH{m_ctrl[0]}}, ovf};
    clr = (en && w && a == 4) ? d[NS-1:0] : '0;
    m_irq = |(m_st & m_ie);
    m_st = (m_st & ~clr) | set;
    m_init_p = 0; m_load_p = 0;
    if (ATOM && en && !w && a == 'h14) m_snap = cin;
    if (en && w) begin
      case (a)
        0: m_ctrl = d & 8'h8B;
        1: m_cin  = d & 8'h71;
        2: m_cout = d & 8'h03;
        3: m_ie   = d[NS-1:0];
        5: m_te   = d[NS-1:0];
        default: ;
      endcase
      if (a >= 8 && b < NB && m_mapped(s)) begin
        if (ATOM && b != NB - 1) m_stage[b] = d;
        else begin
          if (ATOM) begin
            nv = CNT_W'(d) << (8 * (NB - 1));
            for (int k = 0; k < NB - 1; k++)
              nv = nv | (CNT_W'(m_stage[k]) << (8 * k));
          end else begin
            nv = m_wide[s] & ~(CNT_W'(8'hFF) << (8 * b));
            nv = nv | (CNT_W'(d) << (8 * b));
          end
          m_wide[s] = nv;
          if (s == 2) m_init_p = 1;
          if (s == 5) m_load_p = 1;
        end
      end
    end
  endtask

  function automatic logic [511:0] exp_outs();
    logic [N_MATCH*CNT_W-1:0] mv;
    for (int i = 0; i < N_MATCH; i++)
      mv[i*CNT_W +: CNT_W] = m_wide[6+i];
    return 512'({m_ctrl[0], m_ctrl[1], m_ctrl[3], m_ctrl[7],
      m_cin[0], m_cin[6:4], m_cout[0], m_cout[1],
      m_ie[0], m_ie[NS-1:1], m_te[0], m_te[NS-1:1],
      m_wide[2], m_wide[3], m_wide[4], mv,
      m_init_p, m_load_p, m_wide[5], m_st, m_irq});
  endfunction

  // One bus cycle: drive on negedge, sample rdata, step model
  task automatic cyc(input logic en, input logic w,
    input int a, input logic [7:0] d,
    input logic [CNT_W-1:0] cin, input logic ovf,
    input logic [N_MATCH-1:0] m,
    output logic [7:0] rd, output logic [7:0] rx);
    @(negedge clk);
    module_en = en; wr = w; addr = 6'(a); wdata = d;
    count_in = cin; overflow = ovf; match = m;
    #1;
    rd = rdata;
    rx = (en && !w) ? m_read(a, cin) : 8'h00;
    @(posedge clk);
    m_edge(en, w, a, d, cin, ovf, m);
    #1;
    module_en = 0; wr = 0; overflow = 0; match = '0;
  endtask

  task automatic test_reset();
    logic [7:0] rd, rx;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    m_reset();
    #1;
    n_tests++;
    if (act !== exp_outs()) begin
      n_fail++;
      $display("FAIL reset_outs got=%h exp=%h", act, exp_outs());
    end
    n_tests++;
    if (count_max !== 16'hFFFF || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_max_irq max=%h irq=%b exp FFFF/0",
               count_max, irq);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 'h28; a++) begin
      cyc(1, 0, a, 0, CNT_W'($urandom), 0, 0, rd, rx);
      n_tests++;
      if (rd !== rx) begin
        n_fail++;
        $display("FAIL reset_read a=%h got=%h exp=%h", a, rd, rx);
      end
    end
  endtask

`ifdef TIMER_REGS_ATOMIC_EN
  task automatic test_wide_write();
    logic [7:0] rd, rx;
    cyc(1, 1, 'h0C, 8'h34, 0, 0, 0, rd, rx);
    n_tests++;
    if (count_min !== 16'h0000) begin
      n_fail++;
      $display("FAIL min_lsb got=%h exp=0000", count_min);
    end
    cyc(1, 1, 'h0D, 8'h12, 0, 0, 0, rd, rx);
    n_tests++;
    if (count_min !== 16'h1234) begin
      n_fail++;
      $display("FAIL min_msb got=%h exp=1234", count_min);
    end
    cyc(1, 1, 'h14, 8'hCD, 0, 0, 0, rd, rx);
    n_tests++;
    if (cnt_load !== 1'b0) begin
      n_fail++;
      $display("FAIL load_early got=%b exp=0", cnt_load);
    end
    cyc(1, 1, 'h15, 8'hAB, 0, 0, 0, rd, rx);
    n_tests++;
    if (cnt_load !== 1'b1 || cnt_load_val !== 16'hABCD) begin
      n_fail++;
      $display("FAIL load_pulse got=%b/%h exp=1/ABCD",
               cnt_load, cnt_load_val);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, rd, rx);
    n_tests++;
    if (cnt_load !== 1'b0 || cnt_load_val !== 16'hABCD) begin
      n_fail++;
      $display("FAIL load_end got=%b/%h exp=0/ABCD",
               cnt_load, cnt_load_val);
    end
  endtask

  task automatic test_wide_read();
    logic [7:0] rd, rx;
    cyc(1, 0, 'h14, 0, 16'h12FF, 0, 0, rd, rx);
    n_tests++;
    if (rd !== 8'hFF) begin
      n_fail++;
      $display("FAIL snap_lsb got=%h exp=FF", rd);
    end
    cyc(1, 0, 'h15, 0, 16'h1300, 0, 0, rd, rx);
    n_tests++;
    if (rd !== 8'h12) begin
      n_fail++;
      $display("FAIL snap_msb got=%h exp=12", rd);
    end
  endtask
`else
  task automatic test_wide_write();
    logic [7:0] rd, rx;
    cyc(1, 1, 'h0C, 8'h34, 0, 0, 0, rd, rx);
    n_tests++;
    if (count_min !== 16'h0034) begin
      n_fail++;
      $display("FAIL min_byte got=%h exp=0034", count_min);
    end
    cyc(1, 1, 'h14, 8'hCD, 0, 0, 0, rd, rx);
    n_tests++;
    if (cnt_load !== 1'b1 || cnt_load_val !== 16'h00CD) begin
      n_fail++;
      $display("FAIL load_byte got=%b/%h exp=1/00CD",
               cnt_load, cnt_load_val);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, rd, rx);
    n_tests++;
    if (cnt_load !== 1'b0) begin
      n_fail++;
      $display("FAIL load_end got=%b exp=0", cnt_load);
    end
  endtask

  task automatic test_wide_read();
    logic [7:0] rd, rx;
    cyc(1, 0, 'h14, 0, 16'h12FF, 0, 0, rd, rx);
    n_tests++;
    if (rd !== 8'hFF) begin
      n_fail++;
      $display("FAIL live_lsb got=%h exp=FF", rd);
    end
    cyc(1, 0, 'h15, 0, 16'h1300, 0, 0, rd, rx);
    n_tests++;
    if (rd !== 8'h13) begin
      n_fail++;
      $display("FAIL live_msb got=%h exp=13", rd);
    end
  endtask
`endif

  task automatic test_status();
    logic [7:0] rd, rx;
    cyc(1, 1, 'h00, 8'h01, 0, 0, 0, rd, rx);
    cyc(0, 0, 0, 0, 0, 0, 2'b10, rd, rx);
    n_tests++;
    if (status !== 3'b100) begin
      n_fail++;
      $display("FAIL match1_set got=%b exp=100", status);
    end
    cyc(1, 1, 'h03, 8'h04, 0, 0, 0, rd, rx);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_lag got=%b exp=0", irq);
    end
    cyc(1, 0, 'h06, 0, 0, 0, 0, rd, rx);
    n_tests++;
    if (irq !== 1'b1 || rd !== 8'h04) begin
      n_fail++;
      $display("FAIL irq_pend irq=%b pend=%h exp 1/04", irq, rd);
    end
    cyc(1, 1, 'h04, 8'h04, 0, 0, 2'b10, rd, rx);
    n_tests++;
    if (status[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins got=%b exp=1", status[2]);
    end
    cyc(1, 1, 'h04, 8'h04, 0, 0, 0, rd, rx);
    n_tests++;
    if (status[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c got=%b exp=0", status[2]);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, rd, rx);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear got=%b exp=0", irq);
    end
  endtask

  task automatic test_gating();
    logic [7:0] rd, rx;
    cyc(1, 1, 'h00, 8'h00, 0, 0, 0, rd, rx);
    cyc(0, 0, 0, 0, 0, 0, 2'b01, rd, rx);
    n_tests++;
    if (status[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL match_gated got=%b exp=0", status[1]);
    end
    cyc(0, 0, 0, 0, 0, 1, 0, rd, rx);
    n_tests++;
    if (status[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_ungated got=%b exp=1", status[0]);
    end
    cyc(0, 0, 'h03, 0, 0, 0, 0, rd, rx);
    n_tests++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL rd_idle got=%h exp=00", rd);
    end
    cyc(1, 1, 'h20, 8'h55, 0, 0, 0, rd, rx);
    n_tests++;
    if (act !== exp_outs()) begin
      n_fail++;
      $display("FAIL unmapped_wr got=%h exp=%h", act, exp_outs());
    end
    cyc(1, 0, 'h20, 0, 0, 0, 0, rd, rx);
    n_tests++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL unmapped_rd got=%h exp=00", rd);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] rd, rx;
    cyc(1, 1, 'h0C, 8'h34, 0, 0, 0, rd, rx);
    @(negedge clk);
    #2 rst = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 'h0D, 8'h12, 0, 0, 0, rd, rx);
    n_tests++;
    if (count_min !== 16'h1200) begin
      n_fail++;
      $display("FAIL mid_reset got=%h exp=1200", count_min);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, rx, d;
    logic en, w, ovf;
    logic [N_MATCH-1:0] m;
    int a;
    for (int i = 0; i < 600; i++) begin
      en = $urandom_range(0, 7) != 0;
      w  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ?
           $urandom_range(0, 63) : $urandom_range(0, 'h27);
      d  = 8'($urandom);
      ovf = $urandom_range(0, 7) == 0;
      for (int k = 0; k < N_MATCH; k++)
        m[k] = $urandom_range(0, 3) == 0;
      cyc(en, w, a, d, CNT_W'($urandom), ovf, m, rd, rx);
      if (en && !w) begin
        n_tests++;
        if (rd !== rx) begin
          n_fail++;
          $display("FAIL rand_read a=%h got=%h exp=%h", a, rd, rx);
        end
      end
      n_tests++;
      if (act !== exp_outs()) begin
        n_fail++;
        $display("FAIL rand_outs i=%0d got=%h exp=%h",
                 i, act, exp_outs());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    test_reset();
    test_wide_write();
    test_wide_read();
    test_status();
    test_gating();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
